// File: rtl/mlp_controller.sv
// mlp_controller: sequences the MLP datapath through one classification per
// stored sample (62 inputs -> 30 hidden -> 10 outputs on 8 PUs).
//
// state  | meaning
// IDLE   | waiting for start
// PREP   | batch accepted, one setup cycle before the first sample
// WH_CLR | clear datapath counter before hidden-weight load
// WH     | stream hidden weights 0..29 into the PU weight registers
// LX     | load sample s from input memory
// GCLR   | clear counter at the start of a neuron group
// MUL    | multiply slot k
// ADD    | accumulate slot k
// ACT    | apply activation
// WR     | write group results into hidden/output registers
// WO_CLR | clear datapath counter before output-weight load
// WO     | stream output weights 0..9
// LXO    | load hidden activations as the next layer's input
// RES    | present label for sample s
// FIN    | batch complete, done pulse
//
// Ports:
//   clk, rst           clock, async active-high reset
//   start, num_samples batch request (num_samples latched on accept)
//   busy, done         batch status
//   result_valid, result, result_idx   one label per sample
//   cnt_out, out       datapath counter value and classifier label
//   rst_cnt .. ld_out_o  registered datapath controls
module mlp_controller #(
  parameter int N_HID = 30,
  parameter int N_OUT = 10,
  parameter int N_PU  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] num_samples,
  output logic        busy,
  output logic        done,
  output logic        result_valid,
  output logic [3:0]  result,
  output logic [9:0]  result_idx,
  input  logic [4:0]  cnt_out,
  input  logic [3:0]  out,
  output logic        rst_cnt,
  output logic        cnt,
  output logic        mem_read,
  output logic        acc,
  output logic        ld_add,
  output logic        ld_mult,
  output logic        ld_x,
  output logic        sel_h_o,
  output logic [4:0]  addr1,
  output logic [3:0]  addr2,
  output logic [9:0]  addr3,
  output logic [2:0]  sel_64bit,
  output logic [2:0]  sel_reg,
  output logic [29:0] ld,
  output logic [29:0] ld_out_h,
  output logic [9:0]  ld_out_o
);

  localparam logic [4:0] WH_LAST = 5'(N_HID - 1);
  localparam logic [4:0] WO_LAST = 5'(N_OUT - 1);
  localparam logic [2:0] K_LAST  = 3'(N_PU - 1);
  // The output layer only needs the upper half of the MUL slots.
  localparam logic [2:0] K_OUT_FIRST = 3'(N_PU / 2);

  typedef enum logic [3:0] {
    IDLE, PREP, WH_CLR, WH, LX, GCLR, MUL, ADD, ACT, WR,
    WO_CLR, WO, LXO, RES, FIN
  } state_t;

  state_t      state;
  logic [9:0]  s;
  logic [10:0] n_lat;
  logic [1:0]  g;
  logic [2:0]  k;
  logic        ph;        // 0: hidden layer, 1: output layer
  logic        last_smp;

  assign last_smp = ({1'b0, s} == (n_lat - 11'd1));

  // Outputs are registered together with the state, so each branch loads
  // the controls that belong to the state being entered. The datapath
  // counter advances on the same edge, so weight addresses are loaded with
  // the value cnt_out will hold next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      s            <= '0;
      n_lat        <= '0;
      g            <= '0;
      k            <= '0;
      ph           <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      result_idx   <= '0;
      rst_cnt      <= 1'b0;
      cnt          <= 1'b0;
      mem_read     <= 1'b0;
      acc          <= 1'b0;
      ld_add       <= 1'b0;
      ld_mult      <= 1'b0;
      ld_x         <= 1'b0;
      sel_h_o      <= 1'b0;
      addr1        <= '0;
      addr2        <= '0;
      addr3        <= '0;
      sel_64bit    <= '0;
      sel_reg      <= '0;
      ld           <= '0;
      ld_out_h     <= '0;
      ld_out_o     <= '0;
    end else begin
      done         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      result_idx   <= '0;
      rst_cnt      <= 1'b0;
      cnt          <= 1'b0;
      mem_read     <= 1'b0;
      acc          <= 1'b0;
      ld_add       <= 1'b0;
      ld_mult      <= 1'b0;
      ld_x         <= 1'b0;
      sel_h_o      <= 1'b0;
      addr1        <= '0;
      addr2        <= '0;
      addr3        <= '0;
      sel_64bit    <= '0;
      sel_reg      <= '0;
      ld           <= '0;
      ld_out_h     <= '0;
      ld_out_o     <= '0;

      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            n_lat <= num_samples;
            s     <= '0;
            if (num_samples == 11'd0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= PREP;
              busy  <= 1'b1;
            end
          end
        end

        PREP: begin
          state   <= WH_CLR;
          rst_cnt <= 1'b1;
        end

        WH_CLR: begin
          state    <= WH;
          mem_read <= 1'b1;
          cnt      <= 1'b1;
          addr1    <= 5'd0;
          ld       <= 30'd1;
        end

        WH: begin
          if (cnt_out == WH_LAST) begin
            state    <= LX;
            mem_read <= 1'b1;
            ld_x     <= 1'b1;
            addr3    <= s;
          end else begin
            mem_read <= 1'b1;
            cnt      <= 1'b1;
            addr1    <= cnt_out + 5'd1;
            ld       <= 30'd1 << (cnt_out + 5'd1);
          end
        end

        LX: begin
          state   <= GCLR;
          g       <= 2'd0;
          ph      <= 1'b0;
          rst_cnt <= 1'b1;
        end

        GCLR: begin
          state     <= MUL;
          k         <= ph ? K_OUT_FIRST : 3'd0;
          ld_mult   <= 1'b1;
          sel_64bit <= ph ? K_OUT_FIRST : 3'd0;
          sel_reg   <= {1'b0, g};
          sel_h_o   <= ph;
        end

        MUL: begin
          state     <= ADD;
          ld_add    <= 1'b1;
          sel_64bit <= k;
          sel_reg   <= {1'b0, g};
          sel_h_o   <= ph;
        end

        ADD: begin
          sel_reg <= {1'b0, g};
          sel_h_o <= ph;
          if (k == K_LAST) begin
            state <= ACT;
            acc   <= 1'b1;
          end else begin
            state     <= MUL;
            k         <= k + 3'd1;
            ld_mult   <= 1'b1;
            sel_64bit <= k + 3'd1;
          end
        end

        ACT: begin
          state   <= WR;
          sel_reg <= {1'b0, g};
          sel_h_o <= ph;
          if (ph)
            ld_out_o <= g[0] ? 10'h300 : 10'h0FF;
          else if (g == 2'd3)
            ld_out_h <= 30'h3F00_0000;   // last group covers neurons 24..29 only
          else
            ld_out_h <= 30'hFF << {g, 3'b000};
        end

        WR: begin
          if (!ph && g == 2'd3) begin
            state   <= WO_CLR;
            rst_cnt <= 1'b1;
          end else if (ph && g == 2'd1) begin
            state        <= RES;
            result_valid <= 1'b1;
            result       <= out;
            result_idx   <= s;
          end else begin
            state   <= GCLR;
            g       <= g + 2'd1;
            rst_cnt <= 1'b1;
            sel_reg <= {1'b0, g + 2'd1};
            sel_h_o <= ph;
          end
        end

        WO_CLR: begin
          state    <= WO;
          mem_read <= 1'b1;
          sel_h_o  <= 1'b1;
          cnt      <= 1'b1;
          addr2    <= 4'd0;
          ld       <= 30'd1;
        end

        WO: begin
          sel_h_o <= 1'b1;
          if (cnt_out == WO_LAST) begin
            state <= LXO;
            ld_x  <= 1'b1;
          end else begin
            mem_read <= 1'b1;
            cnt      <= 1'b1;
            addr2    <= cnt_out[3:0] + 4'd1;
            ld       <= 30'd1 << (cnt_out + 5'd1);
          end
        end

        LXO: begin
          state   <= GCLR;
          g       <= 2'd0;
          ph      <= 1'b1;
          rst_cnt <= 1'b1;
          sel_h_o <= 1'b1;
        end

        RES: begin
          if (last_smp) begin
            state <= FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state   <= WH_CLR;
            s       <= s + 10'd1;
            rst_cnt <= 1'b1;
          end
        end

        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
